// File: rtl/rotor_offset_scheduler.sv
// rtl/rotor_offset_scheduler.sv - three-rotor modulo-26 offset scheduler over a shared adder
//
// Purpose:
//   Takes one letter (0..25) plus three rotor offsets and adds or subtracts
//   each offset modulo 26. All arithmetic goes through an external shared
//   7-bit adder-subtractor. Each rotor takes one ADD cycle followed by one
//   FIX cycle, which applies a single +/-26 correction when needed. A result
//   therefore appears exactly six edges after the request is accepted.
//
// Configuration:
//   ROTOR_RANGE_CHECK_EN - when defined, an accepted request with in_char > 25
//                          or any pos > 25 is rejected. The block pulses err
//                          for one cycle and stays in IDLE. When undefined,
//                          err is tied to 0 and every request is processed.
//
// Ports:
//   clock, resetn         clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   in_char [6:0]         input letter
//   pos0..pos2 [4:0]      rotor offsets
//   dir                   1 = encipher (add), 0 = decipher (subtract)
//   out_valid / out_ready result handshake; the result is held until accepted
//   out_char [6:0]        result letter (0 when out_valid is low)
//   adder_a, adder_b [6:0], adder_add   operands and mode for the shared adder
//   adder_sum [6:0]       combinational result from the shared adder
//   err                   one-cycle illegal-input pulse

module rotor_offset_scheduler (
  input  logic       clock,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_char,
  input  logic [4:0] pos0,
  input  logic [4:0] pos1,
  input  logic [4:0] pos2,
  input  logic       dir,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_char,
  output logic [6:0] adder_a,
  output logic [6:0] adder_b,
  output logic       adder_add,
  input  logic [6:0] adder_sum,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] MODULUS  = 7'd26;
  localparam logic [6:0] MAX_CHAR = 7'd25;
  localparam logic [4:0] MAX_POS  = 5'd25;
  localparam logic [1:0] LAST_IDX = 2'd2;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [6:0] acc_q, acc_d;
  logic       dir_q, dir_d;
  logic [6:0] pos0_q, pos0_d;
  logic [6:0] pos1_q, pos1_d;
  logic [6:0] pos2_q, pos2_d;

  logic [6:0] pos_sel;
  logic       need_fix;
  logic       accept;

`ifdef ROTOR_RANGE_CHECK_EN
  logic err_q, err_d;
  logic in_bad;
`endif

  // Offset for the rotor currently being applied.
  always_comb begin
    case (idx_q)
      2'd0:    pos_sel = pos0_q;
      2'd1:    pos_sel = pos1_q;
      default: pos_sel = pos2_q;
    endcase
  end

  // Encipher results can only overshoot (max 50) and decipher results can
  // only go negative (min -25). Either way, one +/-26 step brings the value
  // back into 0..25, so bit 6 is a sufficient sign test when subtracting.
  assign need_fix = dir_q ? (acc_q >= MODULUS) : acc_q[6];

  assign accept = (state_q == IDLE) && in_valid;

`ifdef ROTOR_RANGE_CHECK_EN
  assign in_bad = (in_char > MAX_CHAR) || (pos0 > MAX_POS) ||
                  (pos1 > MAX_POS) || (pos2 > MAX_POS);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    dir_d     = dir_q;
    pos0_d    = pos0_q;
    pos1_d    = pos1_q;
    pos2_d    = pos2_q;
    adder_a   = acc_q;
    adder_b   = 7'd0;
    adder_add = 1'b1;
`ifdef ROTOR_RANGE_CHECK_EN
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ROTOR_RANGE_CHECK_EN
          if (in_bad) begin
            // Rejected: acc and the captured operands stay as they were.
            err_d = 1'b1;
          end else begin
            acc_d   = in_char;
            dir_d   = dir;
            pos0_d  = {2'b00, pos0};
            pos1_d  = {2'b00, pos1};
            pos2_d  = {2'b00, pos2};
            idx_d   = 2'd0;
            state_d = ADD;
          end
`else
          acc_d   = in_char;
          dir_d   = dir;
          pos0_d  = {2'b00, pos0};
          pos1_d  = {2'b00, pos1};
          pos2_d  = {2'b00, pos2};
          idx_d   = 2'd0;
          state_d = ADD;
`endif
        end
      end

      ADD: begin
        adder_b   = pos_sel;
        adder_add = dir_q;
        acc_d     = adder_sum;
        state_d   = FIX;
      end

      FIX: begin
        if (need_fix) begin
          // The correction runs opposite to the rotor step.
          adder_b   = MODULUS;
          adder_add = ~dir_q;
          acc_d     = adder_sum;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ADD;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      acc_q   <= 7'd0;
      dir_q   <= 1'b0;
      pos0_q  <= 7'd0;
      pos1_q  <= 7'd0;
      pos2_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      pos0_q  <= pos0_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
    end
  end

`ifdef ROTOR_RANGE_CHECK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_char  = out_valid ? acc_q : 7'd0;

endmodule

// File: doc/rotor_offset_scheduler.md
ROTOR_OFFSET_SCHEDULER -- requirements
Module: rotor_offset_scheduler

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising-edge active.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  request: a letter is presented.
REQ-004 in_ready  out  1  block can accept a request; high only in IDLE.
REQ-005 in_char  in  7  input letter code, legal range 0..25.
REQ-006 pos0, pos1, pos2  in  5 each  rotor offsets, legal range 0..25.
REQ-007 dir  in  1  1 = encipher (add offsets), 0 = decipher (subtract offsets).
REQ-008 out_valid  out  1  result is valid.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 out_char  out  7  result letter, 0..25.
REQ-011 adder_a, adder_b  out  7 each  operands driven to the shared 7-bit adder-subtractor.
REQ-012 adder_add  out  1  adder mode: 1 = A+B, 0 = A-B.
REQ-013 adder_sum  in  7  combinational result returned by the adder.
REQ-014 err  out  1  one-cycle illegal-input pulse; tied 0 when ROTOR_RANGE_CHECK_EN is undefined.

Function
REQ-015 Clocking and reset SHALL be: one clock, clock; reset resetn, asynchronous, active-low.
REQ-016 The FSM SHALL have states IDLE, ADD, FIX and DONE, plus a 2-bit rotor index idx (0..2) and a 7-bit accumulator acc.
- REQ-017 Accept: in_valid and in_ready at an edge.
  - acc, dir and pos0..pos2 are captured; pos values are zero-extended to 7 bits.
  - acc takes in_char; idx takes 0; next state is ADD.
- REQ-018 ADD state:
  - adder_a=acc, adder_b=pos[idx], adder_add=dir.
  - acc takes adder_sum; next state is FIX.
- REQ-019 FIX state, dir=1:
  - If acc>=26, drive adder_a=acc, adder_b=26, adder_add=0, and acc takes adder_sum.
  - Otherwise acc holds.
- REQ-020 FIX state, dir=0:
  - If acc[6]=1 (negative), drive adder_a=acc, adder_b=26, adder_add=1, and acc takes adder_sum.
  - Otherwise acc holds.
- REQ-021 FIX exit:
  - If idx=2, next state is DONE.
  - Otherwise idx increments and next state is ADD.
REQ-022 Latency SHALL be exactly 6 rising edges from the accepting edge to out_valid=1: 3 rotors x (ADD+FIX).
- REQ-023 DONE state: out_valid=1 and out_char=acc.
  - Both SHALL stay stable until out_ready=1 at an edge, then the next state is IDLE.
  - A new request is accepted no earlier than the following edge.
REQ-024 in_valid SHALL be ignored outside IDLE, and in_char, pos0..pos2 and dir may change freely after the accepting edge.
REQ-025 In IDLE and DONE the adder outputs SHALL be adder_a=acc, adder_b=0, adder_add=1; in FIX without correction, adder_b=0.
REQ-026 All arithmetic SHALL be 7-bit modulo 128; legal inputs never exceed 50 or fall below -25, so one correction per rotor suffices.

Reset
REQ-027 While resetn=0, regardless of state (including mid-ADD/FIX):
- state=IDLE, idx=0, acc=0
- out_valid=0, out_char=0, err=0
- in_ready=1
- No transfer is accepted until the first rising edge after resetn returns to 1.

Configuration
- REQ-028 With ROTOR_RANGE_CHECK_EN defined, an accepted request with in_char>25 or any pos>25:
  - SHALL pulse err=1 for exactly one cycle and keep state at IDLE.
  - SHALL produce no out_valid and leave acc unchanged.
- REQ-029 Without ROTOR_RANGE_CHECK_EN:
  - err SHALL be constant 0.
  - Out-of-range inputs SHALL be processed by REQ-017..021 unchanged; the result is unspecified but out_valid timing is per REQ-022.

Verification
REQ-030 Encipher, no wrap: in_char=3, pos=1,2,3, dir=1 -> out_char=9, out_valid 6 edges after accept.
REQ-031 Wrap and underflow:
- in_char=25, pos=1,0,0, dir=1 -> out_char=0.
- in_char=0, pos=1,0,0, dir=0 -> out_char=25.
REQ-032 Maximum: in_char=25, pos=25,25,25, dir=1 -> out_char=22; same with dir=0 on 22 -> 25.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_char and out_valid are stable, in_ready=0, and in_valid pulses are ignored.
REQ-034 Reset in ADD of rotor 1 -> state IDLE, out_valid=0 immediately; the next request completes normally with correct latency.
REQ-035 With ROTOR_RANGE_CHECK_EN: in_char=26 -> err=1 for one cycle, no out_valid; without the macro -> err stays 0, out_valid after 6 edges.
